div_mant_iter: RTL

Iterative radix-2 restoring mantissa divider for the single-precision FPU divide path. It accepts two normalized 24-bit significands, produces a normalized 24-bit quotient significand, and emits the L/G/R/S bit group consumed directly by the downstream division rounder. It also emits an exponent-decrement flag for the exponent path. It sits between FPU operand unpacking/special-case detection and the rounder, and is multi-cycle under a start/done handshake.

---
 rtl/div_mant_iter.sv | 107 ++++++++++
 1 files changed

// File: rtl/div_mant_iter.sv
// Iterative radix-2 restoring significand divider for the FPU divide path.
// Produces a normalized quotient, the {L,G,R,S} group and an exponent-decrement flag.
module div_mant_iter #(
  parameter int MANT_W = 24
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              kill_i,
  input  logic [MANT_W-1:0] mant_a_i,
  input  logic [MANT_W-1:0] mant_b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [MANT_W-1:0] mant_o,
  output logic [3:0]        lgrs_o,
  output logic              exp_dec_o
);

  localparam int Q_W   = MANT_W + 3;
  localparam int K     = MANT_W + 2;
  localparam int CNT_W = $clog2(Q_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(Q_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t            state;
  logic [MANT_W-1:0] divisor;
  logic [MANT_W:0]   rem;
  logic [Q_W-1:0]    quo;
  logic [CNT_W-1:0]  count;

  logic [MANT_W:0]   divisor_ext;
  logic [MANT_W:0]   diff;
  logic [MANT_W:0]   rem_next;
  logic              fits;
  logic              rem_nz;

  // The remainder stays below 2*divisor, so the shifted value never overflows.
  assign divisor_ext = {1'b0, divisor};
  assign fits        = (rem >= divisor_ext);
  assign diff        = rem - divisor_ext;
  assign rem_next    = fits ? {diff[MANT_W-1:0], 1'b0} : {rem[MANT_W-1:0], 1'b0};
  assign rem_nz      = |rem;

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state     <= IDLE;
      divisor   <= '0;
      rem       <= '0;
      quo       <= '0;
      count     <= '0;
      done_o    <= 1'b0;
      mant_o    <= '0;
      lgrs_o    <= '0;
      exp_dec_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !kill_i) begin
            divisor <= mant_b_i;
            rem     <= {1'b0, mant_a_i};
            quo     <= '0;
            count   <= '0;
            state   <= DIV;
          end
        end
        DIV: begin
          if (kill_i) begin
            state <= IDLE;
          end else begin
            quo   <= {quo[Q_W-2:0], fits};
            rem   <= rem_next;
            count <= count + 1'b1;
            if (count == LAST) begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          state <= IDLE;
          if (!kill_i) begin
            // Quotient lies in (0.5, 2): pick the window holding the leading one.
            if (quo[K]) begin
              mant_o    <= quo[K:3];
              lgrs_o    <= {quo[3], quo[2], quo[1], quo[0] | rem_nz};
              exp_dec_o <= 1'b0;
            end else begin
              mant_o    <= quo[K-1:2];
              lgrs_o    <= {quo[2], quo[1], quo[0], rem_nz};
              exp_dec_o <= 1'b1;
            end
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
